ctrl_pipe: RTL
==============

# ctrl_pipe

Carries the decoded control word from the ID stage through the ID/EX, EX/MEM and MEM/WB pipeline registers, and presents each stage's control outputs. Inserts bubbles on load-use stalls. Freezes the whole pipeline on data-memory/cache stalls. Raises the IF/ID flush for taken branches and jumps. It sits between the opcode decoder's outputs (`control_i`, `branch_i`, `jump_i`) and the EX/MEM/WB datapath muxes, ALU control, data memory and register file, and optionally keeps retired-instruction and bubble counters.

## Interface
- `CNT_W`, default 32: width of the performance counters.
- `clk_i`  input  1  clock; all state updates on the rising edge.
- `rst_i`  input  1  reset, synchronous, active-high.
- `control_i`  input  32  decoded control word.
  - Bits: [0] RegWrite, [1] MemToReg, [2] MemWrite, [3] MemRead, [4] RegDst, [6:5] ALUOp, [7] ALUSrc.
  - Bits [31:8] are ignored.
- `branch_i`  input  1  ID instruction is beq.
- `jump_i`  input  1  ID instruction is j.
- `eq_i`  input  1  ID-stage register compare equal.
- `stall_i`  input  1  load-use hazard; insert a bubble into ID/EX.
- `mem_stall_i`  input  1  data-memory busy; freeze all stages.
- `ex_alusrc_o`  output  1  EX ALUSrc.
- `ex_aluop_o`  output  2  EX ALUOp.
- `ex_regdst_o`  output  1  EX RegDst.
- `ex_memread_o`  output  1  EX MemRead, fed back to hazard detection.
- `mem_memread_o`  output  1  MEM MemRead.
- `mem_memwrite_o`  output  1  MEM MemWrite.
- `wb_regwrite_o`  output  1  WB RegWrite.
- `wb_memtoreg_o`  output  1  WB MemToReg.
- `if_flush_o`  output  1  flush IF/ID (combinational).
- `retired_cnt_o`  output  CNT_W  instructions leaving WB.
- `bubble_cnt_o`  output  CNT_W  stall bubbles inserted.

## Operation
- State held:
  - ID/EX register: 8 control bits plus a valid bit.
  - EX/MEM register: MemRead, MemWrite, RegWrite, MemToReg, valid.
  - MEM/WB register: RegWrite, MemToReg, valid.
- Per-edge priority, highest first: `rst_i`, then `mem_stall_i`, then `stall_i`, then normal advance.
- Reset clears every stage register, every valid bit and both counters, so all outputs read 0.
- `mem_stall_i`=1: every register and counter holds; `stall_i` and the decoder inputs are ignored that cycle.
- Advance (`mem_stall_i`=0):
  - EX/MEM takes its fields from ID/EX.
  - MEM/WB takes its fields from EX/MEM.
  - ID/EX loads `control_i[7:0]` with valid=1 when `stall_i`=0.
  - ID/EX loads all-zero with valid=0 (bubble) when `stall_i`=1.
- beq and j occupy pipeline slots: their zero control words enter with valid=1, so they count as retired.
- `if_flush_o` = (`jump_i` | (`branch_i` & `eq_i`)) & ~`stall_i` & ~`mem_stall_i`.
  - A branch whose operands are still stalled does not flush.
  - The branch itself is never squashed by this block.
- Counters:
  - `retired_cnt_o` increments on an advancing edge when MEM/WB valid=1.
  - `bubble_cnt_o` increments on an advancing edge when `stall_i`=1.
  - Both are unsigned modulo 2^CNT_W; all-ones wraps to 0.
- Stage outputs are driven directly from their registers; no combinational path from the inputs reaches them.

## Timing
- A control word accepted at edge N appears on the EX outputs after N, MEM after N+1 and WB after N+2, counting advancing edges only.
- Each frozen cycle adds one cycle of latency per frozen edge.
- `if_flush_o` has zero latency and is valid in the same cycle as its inputs.
- `stall_i` and `mem_stall_i` asserted together: freeze wins, no bubble is inserted, `bubble_cnt_o` holds.
- Reset asserted mid-stream discards all in-flight control words; the first post-reset word is accepted at the first edge with `rst_i`=0.
- Back-to-back stalls insert one bubble per advancing edge.

## Configuration
- `CTRL_PIPE_PERF_EN` defined: both counters are implemented as described above.
- `CTRL_PIPE_PERF_EN` undefined:
  - no counter flops are built;
  - `retired_cnt_o` and `bubble_cnt_o` are tied to 0;
  - all other behaviour is identical.

## Test plan
- Reset, then lw (`control_i`=0x8B) with no stalls:
  - cycle 1: `ex_alusrc_o`=1, `ex_aluop_o`=00, `ex_memread_o`=1;
  - cycle 2: `mem_memread_o`=1;
  - cycle 3: `wb_regwrite_o`=1, `wb_memtoreg_o`=1;
  - `retired_cnt_o`=1 one edge later.
- lw followed by an R-type (0x51) with `stall_i`=1 for one cycle:
  - a bubble is visible in EX (all EX outputs 0);
  - R-type reaches WB one cycle late with `wb_regwrite_o`=1 and `wb_memtoreg_o`=0;
  - `bubble_cnt_o`=1.
- sw (0x84) in MEM with `mem_stall_i` held 3 cycles:
  - `mem_memwrite_o` stays 1 for 4 cycles total;
  - all stage outputs and counters are unchanged during the freeze.
- Flush logic:
  - `branch_i`=1, `eq_i`=1 gives `if_flush_o`=1;
  - `eq_i`=0 gives 0;
  - `jump_i`=1 gives 1;
  - `jump_i`=1 with `stall_i`=1 gives 0.
- Preload counters near the top (CNT_W=4), run 20 R-types: `retired_cnt_o` wraps 15→0.
  - Also assert `rst_i` with 3 instructions in flight: the next cycle all outputs and counters read 0.
- Build with `CTRL_PIPE_PERF_EN` undefined and rerun the stall scenario: identical stage outputs, counters constant 0.

Source files
------------

// File: rtl/ctrl_pipe.sv
// ctrl_pipe: carries decoded control bits from ID through the ID/EX, EX/MEM and
// MEM/WB pipeline registers. It inserts a bubble on a load-use stall, freezes
// every stage on a data-memory stall, and raises the IF/ID flush for taken
// branches and jumps.
// Optional feature: define CTRL_PIPE_PERF_EN to build the retired-instruction
// and bubble counters. When it is undefined, both counter outputs read 0.
module ctrl_pipe #(
    parameter int CNT_W = 32
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [31:0]      control_i,
    input  logic             branch_i,
    input  logic             jump_i,
    input  logic             eq_i,
    input  logic             stall_i,
    input  logic             mem_stall_i,
    output logic             ex_alusrc_o,
    output logic [1:0]       ex_aluop_o,
    output logic             ex_regdst_o,
    output logic             ex_memread_o,
    output logic             mem_memread_o,
    output logic             mem_memwrite_o,
    output logic             wb_regwrite_o,
    output logic             wb_memtoreg_o,
    output logic             if_flush_o,
    output logic [CNT_W-1:0] retired_cnt_o,
    output logic [CNT_W-1:0] bubble_cnt_o
);

    // Bit layout of the ID/EX control byte:
    // [0] RegWrite, [1] MemToReg, [2] MemWrite, [3] MemRead,
    // [4] RegDst, [6:5] ALUOp, [7] ALUSrc
    logic [7:0] id_ex_ctrl;
    logic       id_ex_valid;
    logic       ex_mem_memread;
    logic       ex_mem_memwrite;
    logic       ex_mem_regwrite;
    logic       ex_mem_memtoreg;
    logic       ex_mem_valid;
    logic       mem_wb_regwrite;
    logic       mem_wb_memtoreg;
    logic       mem_wb_valid;
    logic       unused_bits;

    // Pipeline registers: reset clears, memory stall freezes, load-use stall injects a bubble
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            id_ex_ctrl      <= '0;
            id_ex_valid     <= 1'b0;
            ex_mem_memread  <= 1'b0;
            ex_mem_memwrite <= 1'b0;
            ex_mem_regwrite <= 1'b0;
            ex_mem_memtoreg <= 1'b0;
            ex_mem_valid    <= 1'b0;
            mem_wb_regwrite <= 1'b0;
            mem_wb_memtoreg <= 1'b0;
            mem_wb_valid    <= 1'b0;
        end else if (!mem_stall_i) begin
            ex_mem_memread  <= id_ex_ctrl[3];
            ex_mem_memwrite <= id_ex_ctrl[2];
            ex_mem_regwrite <= id_ex_ctrl[0];
            ex_mem_memtoreg <= id_ex_ctrl[1];
            ex_mem_valid    <= id_ex_valid;
            mem_wb_regwrite <= ex_mem_regwrite;
            mem_wb_memtoreg <= ex_mem_memtoreg;
            mem_wb_valid    <= ex_mem_valid;
            if (stall_i) begin
                id_ex_ctrl  <= '0;
                id_ex_valid <= 1'b0;
            end else begin
                id_ex_ctrl  <= control_i[7:0];
                id_ex_valid <= 1'b1;
            end
        end
    end

    assign ex_alusrc_o    = id_ex_ctrl[7];
    assign ex_aluop_o     = id_ex_ctrl[6:5];
    assign ex_regdst_o    = id_ex_ctrl[4];
    assign ex_memread_o   = id_ex_ctrl[3];
    assign mem_memread_o  = ex_mem_memread;
    assign mem_memwrite_o = ex_mem_memwrite;
    assign wb_regwrite_o  = mem_wb_regwrite;
    assign wb_memtoreg_o  = mem_wb_memtoreg;

    // A branch whose operands are still stalled must not redirect fetch yet
    assign if_flush_o = (jump_i | (branch_i & eq_i)) & ~stall_i & ~mem_stall_i;

`ifdef CTRL_PIPE_PERF_EN
    logic [CNT_W-1:0] retired_q;
    logic [CNT_W-1:0] bubble_q;

    // Performance counters advance only on non-frozen edges and wrap modulo 2^CNT_W
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            retired_q <= '0;
            bubble_q  <= '0;
        end else if (!mem_stall_i) begin
            if (mem_wb_valid) begin
                retired_q <= retired_q + CNT_W'(1);
            end
            if (stall_i) begin
                bubble_q <= bubble_q + CNT_W'(1);
            end
        end
    end

    assign retired_cnt_o = retired_q;
    assign bubble_cnt_o  = bubble_q;
    assign unused_bits   = ^control_i[31:8];
`else
    assign retired_cnt_o = '0;
    assign bubble_cnt_o  = '0;
    assign unused_bits   = ^{control_i[31:8], mem_wb_valid};
`endif

endmodule
